gshare_fetch_predictor: RTL and testbench
=========================================

Name: gshare_fetch_predictor

Overview:
- Direction predictor and next-PC selector in the IF stage, sitting directly downstream of the BTB.
- Consumes the BTB's target for the current fetch PC and adds tag/valid qualification that the BTB lacks.
- Adds gshare 2-bit direction prediction and a speculative global history register (GHR).
- Drives the next fetch PC, and the recovery PC/flush when EX resolves a branch or jump.

Parameters:
- IDX_BITS, 5, index width; table index is pc[IDX_BITS+1:2], 32 entries.
- GHR_BITS, 5, global history length; must be <= IDX_BITS.
- CNT_BITS, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- pc_in  in  32  current fetch PC.
- btb_target  in  32  BTB target for pc_in, valid in the same cycle.
- stall  in  1  IF hold; GHR does not shift speculatively.
- pred_taken  out  1  prediction for pc_in.
- pred_next_pc  out  32  btb_target if pred_taken, else pc_in+4.
- pred_ghr  out  GHR_BITS  GHR snapshot; carried down the pipe with the instruction.
- upd_valid  in  1  EX resolves a control-flow instruction this cycle.
- upd_is_jump  in  1  resolved instruction is JAL/JALR (1) or a conditional branch (0).
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual direction; ignored (treated as 1) for jumps.
- upd_target  in  32  actual target.
- upd_pred_taken  in  1  pred_taken carried from IF.
- upd_pred_target  in  32  pred_next_pc carried from IF.
- upd_ghr  in  GHR_BITS  pred_ghr carried from IF.
- flush  out  1  misprediction; IF/ID and ID/EX are squashed.
- recover_pc  out  32  correct next PC when flush=1.
- branch_count  out  CNT_BITS  resolved control-flow instructions.
- mispredict_count  out  CNT_BITS  flushes.

Behaviour:
- State:
  - 32 x {valid, tag = pc[31:IDX_BITS+2], is_jump}.
  - 32 x 2-bit pattern history table (PHT) counters.
  - GHR.
  - Two performance counters.
- Reset (reset=0, async):
  - valid=0; all PHT counters=2'b01 (weakly not-taken); GHR=0; counters=0.
  - Outputs: pred_taken=0, pred_next_pc=pc_in+4, pred_ghr=0, flush=0.
- Prediction (combinational):
  - hit = valid[pc_in idx] && tag match.
  - pht_idx = pc_in[IDX_BITS+1:2] XOR zero-extended GHR.
  - pred_taken = hit && (is_jump || PHT[pht_idx][1]).
- Resolution (combinational):
  - flush = upd_valid && (taken_eff != upd_pred_taken || (taken_eff && upd_target != upd_pred_target)).
  - taken_eff = upd_taken | upd_is_jump.
  - recover_pc = taken_eff ? upd_target : upd_pc+4.
  - flush=0 and recover_pc don't-care when upd_valid=0.
- Training (posedge, upd_valid=1):
  - Conditional branch: PHT[upd_pc idx XOR upd_ghr] saturating +1 if taken, -1 if not taken; saturates at 2'b11 and 2'b00.
  - If taken_eff: tag entry at upd_pc idx <= {1, upd_pc tag, upd_is_jump}, replacing any previous entry.
  - Not-taken conditional branch leaves the tag entry unchanged.
- GHR (posedge), in priority order:
  - 1. flush: GHR <= upd_is_jump ? upd_ghr : {upd_ghr[GHR_BITS-2:0], upd_taken}.
  - 2. else if !stall && hit && !is_jump at pc_in: GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
  - 3. else hold.
- Read/write same entry in one cycle: prediction uses pre-edge contents (no bypass).
- Performance counters:
  - branch_count +1 per upd_valid; mispredict_count +1 per flush.
  - Both saturate at all-ones.
- stall does not block training or flush recovery.

Test Plan:
- Reset, then pc_in=0x100, btb_target=0x200 -> pred_taken=0, pred_next_pc=0x104, pred_ghr=0.
- Resolve JAL: upd_pc=0x100, target 0x200, upd_pred_taken=0 -> flush=1, recover_pc=0x200, mispredict_count=1. Next cycle pc_in=0x100 -> pred_taken=1, pred_next_pc=0x200; pc_in=0x180 (same idx, different tag) -> pred_taken=0.
- Branch at 0x40: two taken updates with upd_ghr=0 -> PHT[16] goes 01->10->11. Then pc_in=0x40, GHR=0 -> pred_taken=1, and GHR shifts to 5'b00001 unless stall=1.
- Four not-taken updates to the same PHT entry -> counter saturates at 00 (no wrap). branch_count = total updates.
- Speculative GHR=5'b10111 when flush arrives with upd_ghr=5'b00011, upd_taken=0 -> GHR=5'b00110 next cycle, overriding the simultaneous speculative shift.
- Assert reset mid-run with a pending upd_valid -> all state cleared immediately, with no clock edge required.

Source files
------------

// File: rtl/gshare_fetch_predictor.sv
// gshare direction predictor and next-PC selector for the IF stage.
// Qualifies the BTB target with a tagged valid/is_jump table, predicts
// conditional branches with a gshare PHT, keeps a speculative GHR and
// produces flush/recovery information when EX resolves control flow.
module gshare_fetch_predictor #(
   parameter int unsigned IDX_BITS = 5,
   parameter int unsigned GHR_BITS = 5,
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         pc_in,
   input  logic [31:0]         btb_target,
   input  logic                stall,
   output logic                pred_taken,
   output logic [31:0]         pred_next_pc,
   output logic [GHR_BITS-1:0] pred_ghr,
   input  logic                upd_valid,
   input  logic                upd_is_jump,
   input  logic [31:0]         upd_pc,
   input  logic                upd_taken,
   input  logic [31:0]         upd_target,
   input  logic                upd_pred_taken,
   input  logic [31:0]         upd_pred_target,
   input  logic [GHR_BITS-1:0] upd_ghr,
   output logic                flush,
   output logic [31:0]         recover_pc,
   output logic [CNT_BITS-1:0] branch_count,
   output logic [CNT_BITS-1:0] mispredict_count
);

   localparam int unsigned ENTRIES  = 1 << IDX_BITS;
   localparam int unsigned TAG_BITS = 32 - IDX_BITS - 2;

   logic [ENTRIES-1:0]  valid_q;
   logic [ENTRIES-1:0]  jump_q;
   logic [TAG_BITS-1:0] tag_q [ENTRIES];
   logic [1:0]          pht_q [ENTRIES];
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;

   logic [IDX_BITS-1:0] fetch_idx;
   logic [IDX_BITS-1:0] fetch_pht_idx;
   logic [TAG_BITS-1:0] fetch_tag;
   logic                fetch_hit;
   logic                fetch_is_jump;

   logic [IDX_BITS-1:0] upd_idx;
   logic [IDX_BITS-1:0] upd_pht_idx;
   logic [TAG_BITS-1:0] upd_tag;
   logic                taken_eff;

   // Fetch-side lookup: tag qualification plus gshare direction
   always_comb begin
      fetch_idx     = pc_in[IDX_BITS+1:2];
      fetch_tag     = pc_in[31:IDX_BITS+2];
      fetch_pht_idx = fetch_idx ^ IDX_BITS'(ghr_q);
      fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
      fetch_is_jump = jump_q[fetch_idx];
      pred_taken    = fetch_hit && (fetch_is_jump || pht_q[fetch_pht_idx][1]);
      pred_next_pc  = pred_taken ? btb_target : pc_in + 32'd4;
      pred_ghr      = ghr_q;
   end

   // Resolution: detect direction or target mispredicts and pick the fix-up PC
   always_comb begin
      upd_idx     = upd_pc[IDX_BITS+1:2];
      upd_tag     = upd_pc[31:IDX_BITS+2];
      upd_pht_idx = upd_idx ^ IDX_BITS'(upd_ghr);
      taken_eff   = upd_taken | upd_is_jump;
      flush       = reset && upd_valid &&
                    ((taken_eff != upd_pred_taken) ||
                     (taken_eff && (upd_target != upd_pred_target)));
      recover_pc  = taken_eff ? upd_target : upd_pc + 32'd4;
   end

   // Next GHR: recovery from the carried snapshot wins over speculative shift
   always_comb begin
      ghr_d = ghr_q;
      if (flush) begin
         ghr_d = upd_is_jump ? upd_ghr : GHR_BITS'({upd_ghr, upd_taken});
      end else if (!stall && fetch_hit && !fetch_is_jump) begin
         ghr_d = GHR_BITS'({ghr_q, pred_taken});
      end
   end

   // GHR register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   // PHT training with 2-bit saturating counters, conditional branches only
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            pht_q[IDX_BITS'(i)] <= 2'b01;
         end
      end else if (upd_valid && !upd_is_jump) begin
         if (upd_taken) begin
            if (pht_q[upd_pht_idx] != 2'b11) begin
               pht_q[upd_pht_idx] <= pht_q[upd_pht_idx] + 2'd1;
            end
         end else if (pht_q[upd_pht_idx] != 2'b00) begin
            pht_q[upd_pht_idx] <= pht_q[upd_pht_idx] - 2'd1;
         end
      end
   end

   // Tag table: taken control flow allocates/replaces the entry at its index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         jump_q  <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[IDX_BITS'(i)] <= '0;
         end
      end else if (upd_valid && taken_eff) begin
         valid_q[upd_idx] <= 1'b1;
         jump_q[upd_idx]  <= upd_is_jump;
         tag_q[upd_idx]   <= upd_tag;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (upd_valid && (branch_count != '1)) begin
            branch_count <= branch_count + CNT_BITS'(1);
         end
         if (flush && (mispredict_count != '1)) begin
            mispredict_count <= mispredict_count + CNT_BITS'(1);
         end
      end
   end

endmodule

// File: tb/tb_gshare_fetch_predictor.sv
// Bench for gshare_fetch_predictor: directed scenarios plus random traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_gshare_fetch_predictor;

   logic        clk;
   logic        reset;
   logic [31:0] pc_in;
   logic [31:0] btb_target;
   logic        stall;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic [4:0]  pred_ghr;
   logic        upd_valid;
   logic        upd_is_jump;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic [4:0]  upd_ghr;
   logic        flush;
   logic [31:0] recover_pc;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   int total;
   int bad;

   // Reference model state
   int m_valid [32];
   int m_tag   [32];
   int m_jmp   [32];
   int m_pht   [32];
   int m_ghr;
   int m_bc;
   int m_mc;

   gshare_fetch_predictor dut (
      .clk              (clk),
      .reset            (reset),
      .pc_in            (pc_in),
      .btb_target       (btb_target),
      .stall            (stall),
      .pred_taken       (pred_taken),
      .pred_next_pc     (pred_next_pc),
      .pred_ghr         (pred_ghr),
      .upd_valid        (upd_valid),
      .upd_is_jump      (upd_is_jump),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken),
      .upd_pred_target  (upd_pred_target),
      .upd_ghr          (upd_ghr),
      .flush            (flush),
      .recover_pc       (recover_pc),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_jmp[i]   = 0;
         m_pht[i]   = 1;
      end
      m_ghr = 0;
      m_bc  = 0;
      m_mc  = 0;
   endtask

   task automatic idle_inputs();
      stall           = 1'b0;
      upd_valid       = 1'b0;
      upd_is_jump     = 1'b0;
      upd_pc          = 32'h0;
      upd_taken       = 1'b0;
      upd_target      = 32'h0;
      upd_pred_taken  = 1'b0;
      upd_pred_target = 32'h0;
      upd_ghr         = 5'd0;
   endtask

   function automatic logic [31:0] rand_pc();
      return 32'(($urandom_range(0, 3) * 128) + ($urandom_range(0, 31) * 4));
   endfunction

   // Check all outputs against the model, then clock once and advance the model.
   task automatic step();
      int fi, ui, pi;
      bit hit, pt, te, fl;
      logic [31:0] exp_next;
      #2;
      fi  = int'((pc_in / 4) % 32);
      hit = (m_valid[fi] != 0) && (m_tag[fi] == int'(pc_in / 128));
      pt  = hit && ((m_jmp[fi] != 0) || (m_pht[fi ^ m_ghr] >= 2));
      exp_next = pt ? btb_target : pc_in + 32'd4;
      te  = upd_taken || upd_is_jump;
      fl  = upd_valid && ((te != upd_pred_taken) || (te && (upd_target != upd_pred_target)));
      check("pred_taken", 32'(pred_taken), 32'(pt));
      check("pred_next_pc", pred_next_pc, exp_next);
      check("pred_ghr", 32'(pred_ghr), 32'(m_ghr));
      check("flush", 32'(flush), 32'(fl));
      if (upd_valid)
         check("recover_pc", recover_pc, te ? upd_target : upd_pc + 32'd4);
      check("branch_count", 32'(branch_count), 32'(m_bc));
      check("mispredict_count", 32'(mispredict_count), 32'(m_mc));
      @(posedge clk);
      if (upd_valid && m_bc < 65535) m_bc++;
      if (fl && m_mc < 65535) m_mc++;
      if (fl)
         m_ghr = upd_is_jump ? int'(upd_ghr) : (int'(upd_ghr) * 2 + int'(upd_taken)) % 32;
      else if (!stall && hit && (m_jmp[fi] == 0))
         m_ghr = (m_ghr * 2 + int'(pt)) % 32;
      if (upd_valid) begin
         ui = int'((upd_pc / 4) % 32);
         if (!upd_is_jump) begin
            pi = ui ^ int'(upd_ghr);
            if (upd_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
            else           m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
         end
         if (te) begin
            m_valid[ui] = 1;
            m_tag[ui]   = int'(upd_pc / 128);
            m_jmp[ui]   = int'(upd_is_jump);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      pc_in = 32'h100;
      btb_target = 32'h200;
      idle_inputs();
      model_reset();

      // Reset state
      @(negedge clk);
      #1;
      check("rst_pred_taken", 32'(pred_taken), 32'd0);
      check("rst_next_pc", pred_next_pc, 32'h104);
      check("rst_ghr", 32'(pred_ghr), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_bc", 32'(branch_count), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Cold lookup
      #1 check("cold_next_pc", pred_next_pc, 32'h104);
      step();

      // JAL resolved as mispredicted
      upd_valid = 1'b1; upd_is_jump = 1'b1; upd_pc = 32'h100; upd_taken = 1'b0;
      upd_target = 32'h200; upd_pred_taken = 1'b0; upd_pred_target = 32'h104; upd_ghr = 5'd0;
      #1;
      check("jal_flush", 32'(flush), 32'd1);
      check("jal_recover", recover_pc, 32'h200);
      step();

      idle_inputs();
      pc_in = 32'h100;
      #1;
      check("jal_mc", 32'(mispredict_count), 32'd1);
      check("jal_hit_taken", 32'(pred_taken), 32'd1);
      check("jal_hit_next", pred_next_pc, 32'h200);
      step();
      pc_in = 32'h180;
      #1 check("alias_miss", 32'(pred_taken), 32'd0);
      step();

      // Branch at 0x40 trained taken twice, correctly predicted
      pc_in = 32'h300; btb_target = 32'h80;
      upd_valid = 1'b1; upd_is_jump = 1'b0; upd_pc = 32'h40; upd_taken = 1'b1;
      upd_target = 32'h80; upd_pred_taken = 1'b1; upd_pred_target = 32'h80; upd_ghr = 5'd0;
      step();
      step();
      idle_inputs();
      pc_in = 32'h40; stall = 1'b1;
      #1;
      check("br_taken", 32'(pred_taken), 32'd1);
      check("br_ghr0", 32'(pred_ghr), 32'd0);
      step();
      #1 check("stall_hold_ghr", 32'(pred_ghr), 32'd0);
      stall = 1'b0;
      step();
      #1 check("spec_shift_ghr", 32'(pred_ghr), 32'd1);

      // Four not-taken resolutions, predicted taken: counter saturates at 00
      pc_in = 32'h300;
      upd_valid = 1'b1; upd_is_jump = 1'b0; upd_pc = 32'h40; upd_taken = 1'b0;
      upd_target = 32'h80; upd_pred_taken = 1'b1; upd_pred_target = 32'h80; upd_ghr = 5'd0;
      repeat (4) step();
      idle_inputs();
      pc_in = 32'h40;
      #1;
      check("sat_low_pred", 32'(pred_taken), 32'd0);
      check("sat_bc", 32'(branch_count), 32'd7);
      check("sat_mc", 32'(mispredict_count), 32'd5);
      step();

      // Flush recovery overrides a simultaneous speculative shift
      pc_in = 32'h300;
      upd_valid = 1'b1; upd_is_jump = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
      upd_target = 32'h200; upd_pred_taken = 1'b0; upd_pred_target = 32'h104; upd_ghr = 5'b10111;
      step();
      #1 check("ghr_set", 32'(pred_ghr), 32'h17);
      pc_in = 32'h40; btb_target = 32'h80;
      upd_is_jump = 1'b0; upd_pc = 32'h40; upd_taken = 1'b0;
      upd_pred_taken = 1'b1; upd_pred_target = 32'h80; upd_ghr = 5'b00011;
      step();
      idle_inputs();
      #1 check("ghr_recover", 32'(pred_ghr), 32'h06);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         pc_in           = rand_pc();
         btb_target      = rand_pc();
         stall           = ($urandom_range(0, 3) == 0);
         upd_valid       = 1'($urandom_range(0, 1));
         upd_is_jump     = ($urandom_range(0, 3) == 0);
         upd_pc          = rand_pc();
         upd_taken       = 1'($urandom_range(0, 1));
         upd_target      = rand_pc();
         upd_pred_taken  = 1'($urandom_range(0, 1));
         upd_pred_target = ($urandom_range(0, 1) == 1) ? upd_target : rand_pc();
         upd_ghr         = 5'($urandom_range(0, 31));
         step();
      end

      // Asynchronous reset with a pending mispredicted update
      pc_in = 32'h100;
      upd_valid = 1'b1; upd_is_jump = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
      upd_target = 32'h240; upd_pred_taken = 1'b0; upd_pred_target = 32'h104; upd_ghr = 5'd9;
      #2 reset = 1'b0;
      #1;
      check("arst_ghr", 32'(pred_ghr), 32'd0);
      check("arst_bc", 32'(branch_count), 32'd0);
      check("arst_mc", 32'(mispredict_count), 32'd0);
      check("arst_flush", 32'(flush), 32'd0);
      check("arst_pred", 32'(pred_taken), 32'd0);
      model_reset();
      @(posedge clk);
      #1 check("arst_hold_bc", 32'(branch_count), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      pc_in = 32'h100;
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
